store_queue: RTL and testbench
==============================

STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, at least 2.
REQ-002 Parameter ADDR_W, default 16, store address width.
REQ-003 Parameter DATA_W, default 16, store data width.
REQ-004 Parameter TAG_W, default 4, reorder tag width.
REQ-005 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-007 Ports alloc_valid / alloc_ready, input / output, 1 each; dispatch handshake for a new store.
REQ-008 Ports alloc_addr (ADDR_W), alloc_data (DATA_W), alloc_tag (TAG_W), inputs; payload of the store being allocated.
REQ-009 Ports commit_valid (1) and commit_tag (TAG_W), inputs; commit notification for one store tag.
REQ-010 Port flush, input, 1; discards all uncommitted entries.
REQ-011 Ports mem_write_en (1), mem_write_addr (ADDR_W), mem_write_data (DATA_W), outputs; memory write request.
REQ-012 Port mem_ready, input, 1; memory accepts the current write request.
REQ-013 Port sq_count, output, clog2(DEPTH)+1 bits; number of occupied entries.

Function
REQ-014 Circular buffer with head/tail pointers modulo DEPTH; each entry holds valid, committed, addr, data and tag.
REQ-015 alloc_ready SHALL be 1 exactly when count < DEPTH and flush = 0; it SHALL NOT depend on a same-cycle pop.
REQ-016 When alloc_valid && alloc_ready, the payload is written at tail with valid=1 and committed=0, and tail increments.
REQ-017 When commit_valid is 1, every valid, uncommitted entry whose tag equals commit_tag becomes committed at the next edge; a tag with no match is ignored.
REQ-018 Commits arrive in program order, so committed entries always form a contiguous prefix starting at head.
REQ-019 mem_write_en SHALL be 1 exactly when the head entry is valid and committed; mem_write_addr and mem_write_data then carry the head entry's payload, and are 0 otherwise.
REQ-020 Commit-to-request latency is 1 cycle: an entry committed at edge N is presented on the memory port during cycle N+1, provided it is at head.
REQ-021 When mem_write_en && mem_ready, the head entry is invalidated and head increments; at most one pop occurs per cycle.
REQ-022 Request outputs SHALL hold stable while mem_write_en = 1 and mem_ready = 0.
REQ-023 When flush is 1, all uncommitted entries are invalidated and tail is set to head plus the number of committed entries; committed entries still drain.
REQ-024 Same-cycle commit and flush: the commit is applied first, then the flush, so the just-committed entry survives.
REQ-025 Same-cycle pop and alloc: both take effect, and count is unchanged.
REQ-026 Same-cycle pop and flush: the pop takes effect and the flush applies to the remaining entries.
REQ-027 sq_count SHALL equal the number of valid entries after every edge and SHALL never exceed DEPTH.

Reset
REQ-028 While reset = 0: all entries are invalid, head = tail = 0, sq_count = 0, mem_write_en = 0, mem_write_addr = 0, mem_write_data = 0, and alloc_ready = 0.
REQ-029 Reset asserted in the middle of an operation discards all entries, including committed entries not yet written; no memory write is issued from that point on.
REQ-030 alloc_ready returns to 1 in the first cycle after reset deasserts.

Configuration
REQ-031 Macro STORE_QUEUE_FWD_EN: when defined, add ports ld_addr (input, ADDR_W), ld_hit (output, 1) and ld_data (output, DATA_W).
REQ-032 With the macro defined, forwarding is combinational: ld_hit = 1 if any valid entry matches ld_addr, and ld_data carries the youngest such entry's data, else 0.
REQ-033 With the macro undefined, the three forwarding ports and their match logic are absent; all other behaviour is identical.

Structure
REQ-034 Shared package store_queue_pkg SHALL hold the default parameter constants and the entry typedef (valid, committed, addr, data, tag).
REQ-035 A single sub-module, sq_fwd_match, SHALL implement the youngest-first address match; it is instantiated only under STORE_QUEUE_FWD_EN.

Verification
REQ-036 Reset, then alloc tag 1 (addr 0x0010, data 0xBEEF), then commit tag 1 with mem_ready = 1 -> mem_write_en = 1 with addr 0x0010 and data 0xBEEF exactly 1 cycle after the commit edge, and sq_count returns to 0.
REQ-037 Alloc 4 stores with DEPTH = 4 -> alloc_ready = 0 and a 5th alloc is dropped; commit and drain one entry -> alloc_ready = 1, and the next alloc wraps to slot 0.
REQ-038 Alloc tags 1, 2, 3; commit tag 1; flush -> sq_count = 1, and only tag 1's write appears on the memory port.
REQ-039 Committed head with mem_ready held at 0 for 3 cycles -> request outputs stay stable, no pop occurs, and sq_count is unchanged.
REQ-040 With STORE_QUEUE_FWD_EN defined: stores to 0x0020 with data 0x1111 then 0x2222, and ld_addr = 0x0020 -> ld_hit = 1 and ld_data = 0x2222; with ld_addr = 0x0030 -> ld_hit = 0 and ld_data = 0.
REQ-041 Reset asserted mid-drain with 2 committed entries -> mem_write_en falls immediately and sq_count = 0; no write is issued after reset deasserts.

Source files
------------

// File: rtl/store_queue_pkg.sv
// Shared constants and entry layout for the store queue and its helpers.
// Default parameter values live here so every user of the queue agrees on them.
package store_queue_pkg;

    localparam int DEFAULT_DEPTH  = 4;
    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_TAG_W  = 4;

    typedef struct packed {
        logic                      valid;
        logic                      committed;
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [DEFAULT_DATA_W-1:0] data;
        logic [DEFAULT_TAG_W-1:0]  tag;
    } sq_entry_t;

endpackage

// File: rtl/sq_fwd_match.sv
// Youngest-first address match over the store queue, used for store-to-load forwarding.
// Scans from head (oldest) toward tail so the last hit seen is the youngest store.
module sq_fwd_match
    import store_queue_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DEPTH-1:0]         valid,
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [ADDR_W-1:0]        addr [DEPTH],
    input  logic [DATA_W-1:0]        data [DEPTH],
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     hit,
    output logic [DATA_W-1:0]        ld_data
);

    localparam int PTR_W = $clog2(DEPTH);

    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        hit     = 1'b0;
        ld_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && addr[idx] == ld_addr) begin
                hit     = 1'b1;
                ld_data = data[idx];
            end
        end
    end

endmodule

// File: rtl/store_queue.sv
// Store queue: holds dispatched stores until commit, then drains them in order to memory.
// Optional store-to-load forwarding ports are enabled by defining STORE_QUEUE_FWD_EN.
module store_queue
    import store_queue_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int TAG_W  = DEFAULT_TAG_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [ADDR_W-1:0]        alloc_addr,
    input  logic [DATA_W-1:0]        alloc_data,
    input  logic [TAG_W-1:0]         alloc_tag,
    input  logic                     commit_valid,
    input  logic [TAG_W-1:0]         commit_tag,
    input  logic                     flush,
    output logic                     mem_write_en,
    output logic [ADDR_W-1:0]        mem_write_addr,
    output logic [DATA_W-1:0]        mem_write_data,
    input  logic                     mem_ready,
`ifdef STORE_QUEUE_FWD_EN
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_hit,
    output logic [DATA_W-1:0]        ld_data,
`endif
    output logic [$clog2(DEPTH):0]   sq_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head, tail, head_n, tail_n;
    logic [CNT_W-1:0]  count, count_n, ncomm;
    logic [DEPTH-1:0]  ent_valid, ent_comm, valid_n, comm_n, commit_hit;
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [TAG_W-1:0]  ent_tag  [DEPTH];
    logic              alloc_fire, pop;

    assign alloc_ready    = reset && (count < CNT_W'(DEPTH)) && !flush;
    assign alloc_fire     = alloc_valid && alloc_ready;
    assign mem_write_en   = ent_valid[head] && ent_comm[head];
    assign pop            = mem_write_en && mem_ready;
    assign mem_write_addr = mem_write_en ? ent_addr[head] : '0;
    assign mem_write_data = mem_write_en ? ent_data[head] : '0;
    assign sq_count       = count;

    // Order of application: commit, then pop, then flush, then alloc (alloc is never
    // concurrent with flush). Committed entries form a prefix from head, so the
    // post-flush tail is simply head plus the committed count.
    always_comb begin
        commit_hit = '0;
        ncomm      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (commit_valid && ent_valid[i] && !ent_comm[i] && ent_tag[i] == commit_tag)
                commit_hit[i] = 1'b1;
        end
        comm_n = ent_comm | commit_hit;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && comm_n[i])
                ncomm = ncomm + CNT_W'(1);
        end
        valid_n = ent_valid;
        if (pop) begin
            valid_n[head] = 1'b0;
            comm_n[head]  = 1'b0;
        end
        if (flush)
            valid_n = valid_n & comm_n;
        if (alloc_fire) begin
            valid_n[tail] = 1'b1;
            comm_n[tail]  = 1'b0;
        end
        comm_n = comm_n & valid_n;
        head_n = head + PTR_W'(pop);
        if (flush) begin
            tail_n  = head + ncomm[PTR_W-1:0];
            count_n = ncomm - CNT_W'(pop);
        end else begin
            tail_n  = tail + PTR_W'(alloc_fire);
            count_n = count + CNT_W'(alloc_fire) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_comm  <= '0;
        end else begin
            head      <= head_n;
            tail      <= tail_n;
            count     <= count_n;
            ent_valid <= valid_n;
            ent_comm  <= comm_n;
        end
    end

    // Payload needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_addr[tail] <= alloc_addr;
            ent_data[tail] <= alloc_data;
            ent_tag[tail]  <= alloc_tag;
        end
    end

`ifdef STORE_QUEUE_FWD_EN
    sq_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd (
        .valid   (ent_valid),
        .head    (head),
        .addr    (ent_addr),
        .data    (ent_data),
        .ld_addr (ld_addr),
        .hit     (ld_hit),
        .ld_data (ld_data)
    );
`endif

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: scoreboard of expected memory writes plus per-scenario checks.
// Forwarding scenario is included when STORE_QUEUE_FWD_EN is defined.
module tb_store_queue;
    import store_queue_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid, alloc_ready;
    logic [15:0] alloc_addr, alloc_data;
    logic [3:0]  alloc_tag;
    logic        commit_valid;
    logic [3:0]  commit_tag;
    logic        flush;
    logic        mem_write_en;
    logic [15:0] mem_write_addr, mem_write_data;
    logic        mem_ready;
    logic [2:0]  sq_count;
`ifdef STORE_QUEUE_FWD_EN
    logic [15:0] ld_addr;
    logic        ld_hit;
    logic [15:0] ld_data;
`endif

    sq_entry_t exp_q[$];
    sq_entry_t mon_e;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    store_queue #(.DEPTH(4), .ADDR_W(16), .DATA_W(16), .TAG_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_addr     (alloc_addr),
        .alloc_data     (alloc_data),
        .alloc_tag      (alloc_tag),
        .commit_valid   (commit_valid),
        .commit_tag     (commit_tag),
        .flush          (flush),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_ready      (mem_ready),
`ifdef STORE_QUEUE_FWD_EN
        .ld_addr        (ld_addr),
        .ld_hit         (ld_hit),
        .ld_data        (ld_data),
`endif
        .sq_count       (sq_count)
    );

    // Every accepted memory write must match the oldest expected store.
    always @(negedge clk) begin
        if (reset && mem_write_en && mem_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         mem_write_addr, mem_write_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_write_addr !== mon_e.addr || mem_write_data !== mon_e.data) begin
                    n_err++;
                    $display("FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h",
                             mem_write_addr, mem_write_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [15:0] a, input logic [15:0] d, input logic [3:0] t);
        alloc_valid = 1'b1;
        alloc_addr  = a;
        alloc_data  = d;
        alloc_tag   = t;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic expect_write(input logic [15:0] a, input logic [15:0] d, input logic [3:0] t);
        sq_entry_t e;
        e.valid     = 1'b1;
        e.committed = 1'b1;
        e.addr      = a;
        e.data      = d;
        e.tag       = t;
        exp_q.push_back(e);
    endtask

    task automatic commit(input logic [3:0] t);
        commit_valid = 1'b1;
        commit_tag   = t;
        step();
        commit_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        mem_ready = 1'b1;
        while (sq_count !== 3'd0 && cyc < 20) begin
            step();
            cyc++;
        end
        mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        alloc_valid  = 1'b0;
        commit_valid = 1'b0;
        flush        = 1'b0;
        mem_ready    = 1'b0;
        exp_q.delete();
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        alloc_valid  = 1'b1;
        alloc_addr   = 16'h1234;
        alloc_data   = 16'h5678;
        alloc_tag    = 4'd3;
        commit_valid = 1'b0;
        commit_tag   = 4'd0;
        flush        = 1'b0;
        mem_ready    = 1'b1;
`ifdef STORE_QUEUE_FWD_EN
        ld_addr      = 16'h0000;
`endif
        step();
        step();
        n_cmp++;
        if (sq_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d, required 0", sq_count); end
        n_cmp++;
        if (mem_write_en !== 1'b0 || mem_write_addr !== 16'h0 || mem_write_data !== 16'h0) begin
            n_err++;
            $display("FAIL reset_mem: got en=%b addr=%h data=%h, required 0/0/0", mem_write_en, mem_write_addr, mem_write_data);
        end
        n_cmp++;
        if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL reset_alloc_ready: got %b, required 0", alloc_ready); end
        alloc_valid = 1'b0;
        mem_ready   = 1'b0;
        reset       = 1'b1;
        #1;
        n_cmp++;
        if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b, required 1", alloc_ready); end
    endtask

    task automatic test_single();
        alloc(16'h0010, 16'hBEEF, 4'd1);
        n_cmp++;
        if (sq_count !== 3'd1 || mem_write_en !== 1'b0) begin
            n_err++;
            $display("FAIL single_alloc: got count=%0d en=%b, required 1/0", sq_count, mem_write_en);
        end
        mem_ready = 1'b1;
        expect_write(16'h0010, 16'hBEEF, 4'd1);
        commit(4'd1);
        n_cmp++;
        if (mem_write_en !== 1'b1 || mem_write_addr !== 16'h0010 || mem_write_data !== 16'hBEEF) begin
            n_err++;
            $display("FAIL single_latency: got en=%b addr=%h data=%h, required 1/0010/beef",
                     mem_write_en, mem_write_addr, mem_write_data);
        end
        step();
        n_cmp++;
        if (sq_count !== 3'd0 || mem_write_en !== 1'b0) begin
            n_err++;
            $display("FAIL single_drained: got count=%0d en=%b, required 0/0", sq_count, mem_write_en);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++)
            alloc(16'h0100 + 16'(i), 16'hA000 + 16'(i), 4'(i + 1));
        n_cmp++;
        if (sq_count !== 3'd4 || alloc_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_state: got count=%0d ready=%b, required 4/0", sq_count, alloc_ready);
        end
        alloc(16'h0DEA, 16'hDEAD, 4'd9);
        n_cmp++;
        if (sq_count !== 3'd4) begin n_err++; $display("FAIL full_drop: got count=%0d, required 4", sq_count); end
        expect_write(16'h0100, 16'hA000, 4'd1);
        commit(4'd1);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        n_cmp++;
        if (sq_count !== 3'd3 || alloc_ready !== 1'b1 || mem_write_en !== 1'b0) begin
            n_err++;
            $display("FAIL full_pop_one: got count=%0d ready=%b en=%b, required 3/1/0", sq_count, alloc_ready, mem_write_en);
        end
        alloc(16'h0104, 16'hA004, 4'd5);
        n_cmp++;
        if (sq_count !== 3'd4) begin n_err++; $display("FAIL full_wrap_alloc: got count=%0d, required 4", sq_count); end
        for (int i = 1; i < 5; i++) begin
            expect_write(16'h0100 + 16'(i), 16'hA000 + 16'(i), 4'(i + 1));
            commit(4'(i + 1));
        end
        commit(4'd9);
        drain();
        n_cmp++;
        if (sq_count !== 3'd0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL full_drain: got count=%0d pending=%0d, required 0/0", sq_count, exp_q.size());
        end
    endtask

    task automatic test_flush();
        alloc(16'h0200, 16'hB001, 4'd1);
        alloc(16'h0202, 16'hB002, 4'd2);
        alloc(16'h0204, 16'hB003, 4'd3);
        expect_write(16'h0200, 16'hB001, 4'd1);
        commit(4'd1);
        flush = 1'b1;
        #1;
        n_cmp++;
        if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b, required 0", alloc_ready); end
        step();
        flush = 1'b0;
        n_cmp++;
        if (sq_count !== 3'd1 || mem_write_addr !== 16'h0200) begin
            n_err++;
            $display("FAIL flush_count: got count=%0d addr=%h, required 1/0200", sq_count, mem_write_addr);
        end
        drain();
        n_cmp++;
        if (sq_count !== 3'd0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL flush_drain: got count=%0d pending=%0d, required 0/0", sq_count, exp_q.size());
        end
        alloc(16'h0300, 16'hC004, 4'd4);
        alloc(16'h0302, 16'hC005, 4'd5);
        expect_write(16'h0300, 16'hC004, 4'd4);
        flush = 1'b1;
        commit(4'd4);
        flush = 1'b0;
        n_cmp++;
        if (sq_count !== 3'd1) begin n_err++; $display("FAIL commit_flush_count: got %0d, required 1", sq_count); end
        drain();
        n_cmp++;
        if (sq_count !== 3'd0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL commit_flush_drain: got count=%0d pending=%0d, required 0/0", sq_count, exp_q.size());
        end
    endtask

    task automatic test_stall();
        logic [15:0] a0, d0;
        alloc(16'h0400, 16'hD007, 4'd7);
        expect_write(16'h0400, 16'hD007, 4'd7);
        commit(4'd7);
        a0 = mem_write_addr;
        d0 = mem_write_data;
        n_cmp++;
        if (mem_write_en !== 1'b1 || a0 !== 16'h0400 || d0 !== 16'hD007) begin
            n_err++;
            $display("FAIL stall_start: got en=%b addr=%h data=%h, required 1/0400/d007", mem_write_en, a0, d0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (mem_write_en !== 1'b1 || mem_write_addr !== a0 || mem_write_data !== d0 || sq_count !== 3'd1) begin
                n_err++;
                $display("FAIL stall_hold: got en=%b addr=%h data=%h count=%0d, required 1/%h/%h/1",
                         mem_write_en, mem_write_addr, mem_write_data, sq_count, a0, d0);
            end
        end
        drain();
        n_cmp++;
        if (sq_count !== 3'd0) begin n_err++; $display("FAIL stall_drain: got %0d, required 0", sq_count); end
    endtask

    task automatic test_back_to_back();
        alloc(16'h0500, 16'hE001, 4'd1);
        expect_write(16'h0500, 16'hE001, 4'd1);
        commit(4'd1);
        alloc(16'h0502, 16'hE002, 4'd2);
        mem_ready = 1'b1;
        alloc(16'h0504, 16'hE003, 4'd3);
        mem_ready = 1'b0;
        n_cmp++;
        if (sq_count !== 3'd2) begin n_err++; $display("FAIL pop_alloc_count: got %0d, required 2", sq_count); end
        expect_write(16'h0502, 16'hE002, 4'd2);
        commit(4'd2);
        expect_write(16'h0504, 16'hE003, 4'd3);
        commit(4'd3);
        drain();
        n_cmp++;
        if (sq_count !== 3'd0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pop_alloc_drain: got count=%0d pending=%0d, required 0/0", sq_count, exp_q.size());
        end
        alloc(16'h0600, 16'hF001, 4'd1);
        alloc(16'h0602, 16'hF002, 4'd2);
        alloc(16'h0604, 16'hF003, 4'd3);
        expect_write(16'h0600, 16'hF001, 4'd1);
        commit(4'd1);
        expect_write(16'h0602, 16'hF002, 4'd2);
        commit(4'd2);
        mem_ready = 1'b1;
        flush     = 1'b1;
        step();
        mem_ready = 1'b0;
        flush     = 1'b0;
        n_cmp++;
        if (sq_count !== 3'd1) begin n_err++; $display("FAIL pop_flush_count: got %0d, required 1", sq_count); end
        drain();
        n_cmp++;
        if (sq_count !== 3'd0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pop_flush_drain: got count=%0d pending=%0d, required 0/0", sq_count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        alloc(16'h0700, 16'h7001, 4'd1);
        alloc(16'h0702, 16'h7002, 4'd2);
        expect_write(16'h0700, 16'h7001, 4'd1);
        commit(4'd1);
        expect_write(16'h0702, 16'h7002, 4'd2);
        commit(4'd2);
        mem_ready = 1'b1;
        step();
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (mem_write_en !== 1'b0 || sq_count !== 3'd0 || alloc_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got en=%b count=%0d ready=%b, required 0/0/0", mem_write_en, sq_count, alloc_ready);
        end
        exp_q.delete();
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (mem_write_en !== 1'b0 || sq_count !== 3'd0) begin
            n_err++;
            $display("FAIL post_mid_reset: got en=%b count=%0d, required 0/0", mem_write_en, sq_count);
        end
        mem_ready = 1'b0;
    endtask

`ifdef STORE_QUEUE_FWD_EN
    task automatic test_fwd();
        do_reset();
        alloc(16'h0020, 16'h1111, 4'd1);
        alloc(16'h0020, 16'h2222, 4'd2);
        ld_addr = 16'h0020;
        #1;
        n_cmp++;
        if (ld_hit !== 1'b1 || ld_data !== 16'h2222) begin
            n_err++;
            $display("FAIL fwd_hit: got hit=%b data=%h, required 1/2222", ld_hit, ld_data);
        end
        ld_addr = 16'h0030;
        #1;
        n_cmp++;
        if (ld_hit !== 1'b0 || ld_data !== 16'h0000) begin
            n_err++;
            $display("FAIL fwd_miss: got hit=%b data=%h, required 0/0000", ld_hit, ld_data);
        end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_full();
        test_flush();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef STORE_QUEUE_FWD_EN
        test_fwd();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
